// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings: parity modes, Rx states, error flag bits
package uart_pkg;

    localparam logic [1:0] ODD        = 2'b01;
    localparam logic [1:0] EVEN       = 2'b10;
    localparam logic [1:0] NOPARITY00 = 2'b00;
    localparam logic [1:0] NOPARITY11 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CHECK
    } rx_state_t;

    localparam int PAR_ERR   = 0;
    localparam int START_ERR = 1;
    localparam int STOP_ERR  = 2;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == ODD) || (mode == EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the idle-high serial line
module uart_rx_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Resolve metastability over two stages; reset to the idle (high) level
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART Rx frame sequencer with checker hand-off and consumer handshake
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       baud_tick,
    input  logic       rx_serial,
    input  logic [1:0] parity_type,
    input  logic [2:0] error_flag,
    input  logic       data_ack,
    output logic [7:0] raw_data,
    output logic       start_bit,
    output logic       stop_bit,
    output logic       parity_bit,
    output logic [7:0] rx_data,
    output logic [2:0] rx_error,
    output logic       rx_valid,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_t         state;
    logic [TW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [1:0]        par_mode;
    logic              rxs;

    // New bits enter at the top of the data field so the first bit lands at bit 0
    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
        logic [7:0] r;
        r = cur >> 1;
        r[DATA_BITS-1] = b;
        return r;
    endfunction

    uart_rx_sync u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rx_serial),
        .q       (rxs)
    );

    assign busy = (state != IDLE);

    // Frame sequencer: mid-bit sampling, field capture and delivery to the consumer
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            par_mode   <= NOPARITY00;
            raw_data   <= 8'h00;
            start_bit  <= 1'b0;
            stop_bit   <= 1'b1;
            parity_bit <= 1'b1;
            rx_data    <= 8'h00;
            rx_error   <= 3'b000;
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (rx_valid && data_ack) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (baud_tick && !rxs) begin
                        state    <= START;
                        tick_cnt <= '0;
                        par_mode <= parity_type;
                    end
                end

                START: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            if (rxs) begin
                                state <= IDLE;
                            end else begin
                                start_bit <= 1'b0;
                                bit_cnt   <= '0;
                                state     <= DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                DATA: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            raw_data <= shift_in(raw_data, rxs);
                            bit_cnt  <= bit_cnt + BW'(1);
                            if (bit_cnt == BIT_LAST) begin
                                if (parity_enabled(par_mode)) begin
                                    state <= PARITY;
                                end else begin
                                    parity_bit <= 1'b1;
                                    state      <= STOP;
                                end
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                PARITY: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt   <= '0;
                            parity_bit <= rxs;
                            state      <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                STOP: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            stop_bit <= rxs;
                            state    <= CHECK;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                CHECK: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    if (rx_valid && !data_ack) begin
                        overrun <= 1'b1;
                    end else begin
                        rx_valid <= 1'b1;
                        rx_data  <= raw_data;
                        rx_error <= error_flag;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Receive-side frame sequencer for the UART Rx path. It synchronises the serial line, detects start, and samples start/data/parity/stop bits mid-bit on an oversampled baud tick. It presents the assembled frame fields to the Rx error checker, captures the checker's 3-bit error flags one cycle later, and hands the byte to the consumer over a valid/ack handshake with overrun detection.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first (checker interface fixed at 8)
OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=4)

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous active-low reset
baud_tick  input  1  one-cycle strobe at OVERSAMPLE x baud rate
rx_serial  input  1  asynchronous serial line, idle high
parity_type  input  2  01 ODD, 10 EVEN, 00/11 no parity
error_flag  input  3  from checker: [0] parity, [1] start, [2] stop
data_ack  input  1  consumer accepts rx_data
raw_data  output  8  assembled data to checker
start_bit  output  1  sampled start bit to checker
stop_bit  output  1  sampled stop bit to checker
parity_bit  output  1  sampled parity bit to checker; 1 when no parity
rx_data  output  8  delivered byte
rx_error  output  3  error_flag captured for rx_data
rx_valid  output  1  rx_data/rx_error valid, held until data_ack
overrun  output  1  sticky: frame completed while rx_valid high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (clock edge with reset_n=0): state IDLE, counters 0, synchroniser flops 1, raw_data 0, start_bit 0, stop_bit 1, parity_bit 1, rx_data 0, rx_error 0, rx_valid 0, overrun 0. A mid-frame reset abandons the frame with no output.
- rx_serial passes through a 2-flop synchroniser (rxs). All sampling uses rxs.
- tick_cnt: $clog2(OVERSAMPLE) bits. Advances only on baud_tick and clears on each state entry.
- IDLE: on baud_tick with rxs=0, go to START and latch parity_type into par_mode. par_mode is frozen for the whole frame.
- START: at tick_cnt==OVERSAMPLE/2-1 on baud_tick (mid start bit), sample rxs.
  - rxs=1: false start. Return to IDLE with no output change.
  - rxs=0: start_bit<=0, go to DATA.
- DATA: sample on every OVERSAMPLE-th baud_tick and shift right into raw_data from the MSB, so the first bit received ends up at raw_data[0]. After DATA_BITS samples: go to PARITY if par_mode is 01/10, else go to STOP with parity_bit<=1.
- PARITY: sample once after OVERSAMPLE ticks into parity_bit, then go to STOP.
- STOP: sample once after OVERSAMPLE ticks into stop_bit, then go to CHECK. No wait for the end of the stop bit, so back-to-back frames are supported.
- CHECK: exactly one clock, with no baud_tick dependence. This gives the combinational checker time to settle on the registered fields. At the end of CHECK:
  - rx_data<=raw_data, rx_error<=error_flag, go to IDLE.
  - If rx_valid is already 1 and data_ack is not asserted this cycle: set overrun<=1, keep the old rx_data/rx_error, and drop the new frame.
  - Otherwise: rx_valid<=1 and load the new frame.
- Handshake: rx_valid falls on the cycle after data_ack with rx_valid=1. data_ack and CHECK in the same cycle: the new frame is loaded and rx_valid stays 1, with no overrun. data_ack while rx_valid=0 is ignored.
- overrun clears only on reset.
- Latency: rx_valid rises 1 clock after the stop-bit sample edge.
- The error flags come from the checker, not from this block. A frame with bad start or stop is still delivered, with rx_error set.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings ODD=2'b01, EVEN=2'b10, NOPARITY00=2'b00, NOPARITY11=2'b11
  - Rx state encodings IDLE, START, DATA, PARITY, STOP, CHECK
  - error_flag bit indices PAR_ERR=0, START_ERR=1, STOP_ERR=2
- One natural sub-module: uart_rx_sync, the 2-flop synchroniser with reset value 1.
- The checker is instantiated beside this block at the Rx top, not inside it.

Test Plan:
- 8N1 frame 0xA5, parity_type=00, checker returns 000 -> rx_valid=1, rx_data=8'hA5, rx_error=3'b000, parity_bit=1.
- Even parity, data 0x03, parity bit sent 1 (wrong), checker returns 001 -> rx_data=8'h03, rx_error=3'b001.
- Glitch: line low for 3 ticks then high (OVERSAMPLE=16) -> state returns to IDLE, rx_valid stays 0, busy falls after 8 ticks.
- Stop bit sent 0, data 0x7E, checker returns 100 -> rx_valid=1, rx_data=8'h7E, rx_error=3'b100.
- Two frames 0x11 then 0x22 back-to-back, no data_ack -> rx_data stays 8'h11, overrun=1. Then data_ack -> rx_valid=0 next cycle, overrun stays 1.
- reset_n=0 asserted mid-DATA, released, then full frame 0x5A -> no output from the aborted frame, then rx_data=8'h5A, busy=0 after CHECK.
